// File: rtl/b16_uart_if.sv
// b16 CPU data-bus signals seen by the UART register window.
// The CPU drives addr/rd/wr/din; the UART answers on dout.
interface b16_uart_if #(
   parameter int unsigned l = 16
);
   logic [l-1:1] addr;
   logic         rd;
   logic [1:0]   wr;
   logic [l-1:0] din;
   logic [l-1:0] dout;

   modport master (output addr, rd, wr, din, input dout);
   modport slave  (input addr, rd, wr, din, output dout);
endinterface

// File: rtl/b16_uart.sv
// Memory-mapped 8N1 UART for the b16 bus: DATA/STAT/DIV/CTRL registers, TX and RX FIFOs, level irq.
// Optional UART_LOOPBACK_EN: CTRL bit2 routes the TX serializer into the RX path and holds txd high.
module b16_uart #(
   parameter int unsigned l      = 16,
   parameter logic [11:0] ioaddr = 12'hFFD,
   parameter int unsigned fdep   = 2,
   parameter logic [15:0] divrst = 16'd433
) (
   input  logic      clk,
   input  logic      reset,
   b16_uart_if.slave bus,
   output logic      irq,
   output logic      txd,
   input  logic      rxd
);
   localparam int unsigned depth = 1 << fdep;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

   logic        sel, wr_any, data_wr, stat_wr, div_wr, ctrl_wr, data_rd;
   logic [2:0]  idx;
   logic [7:0]  wbyte;
   logic [15:0] div;
   logic        rxie, txie, loop, ferr, ovr, ferr_set;
   logic        tx_ser, rx_in;

   logic [7:0]  tx_mem [depth];
   logic [7:0]  rx_mem [depth];
   logic [fdep:0] tx_wp, tx_rp, rx_wp, rx_rp;
   logic        tx_empty, tx_full, rx_ne, rx_full;
   logic        tx_pop, tx_push, rx_pop, rx_push, rx_wr;
   logic [7:0]  rx_head;

   tx_state_t   tx_state, tx_next;
   logic [15:0] tx_cnt, tx_div;
   logic [7:0]  tx_sh;
   logic [2:0]  tx_bit;
   logic        tx_load;

   rx_state_t   rx_state, rx_next;
   logic [15:0] rx_cnt, rx_div, rx_half;
   logic [7:0]  rx_sh;
   logic [2:0]  rx_bit;
   logic        rx_detect, rx_tick, s1, s2, s3;

   assign sel     = (bus.addr[l-1:4] == ioaddr);
   assign idx     = bus.addr[3:1];
   assign wr_any  = sel && (bus.wr != 2'b00);
   assign data_wr = wr_any && (idx == 3'd0);
   assign stat_wr = wr_any && (idx == 3'd1);
   assign div_wr  = wr_any && (idx == 3'd2);
   assign ctrl_wr = wr_any && (idx == 3'd3);
   assign data_rd = sel && bus.rd && (idx == 3'd0);
   assign wbyte   = bus.wr[0] ? bus.din[7:0] : bus.din[15:8];

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[fdep] != tx_rp[fdep]) && (tx_wp[fdep-1:0] == tx_rp[fdep-1:0]);
   assign rx_ne    = (rx_wp != rx_rp);
   assign rx_full  = (rx_wp[fdep] != rx_rp[fdep]) && (rx_wp[fdep-1:0] == rx_rp[fdep-1:0]);
   assign rx_head  = rx_mem[rx_rp[fdep-1:0]];
   assign rx_pop   = data_rd && rx_ne;
   assign tx_pop   = tx_load;
   assign tx_push  = data_wr && (!tx_full || tx_pop);
   assign rx_wr    = rx_push && (!rx_full || rx_pop);

`ifdef UART_LOOPBACK_EN
   always_ff @(posedge clk) begin
      if (reset) loop <= 1'b0;
      else if (ctrl_wr && bus.wr[0]) loop <= bus.din[2];
   end
   assign rx_in = loop ? tx_ser : rxd;
   assign txd   = loop ? 1'b1 : tx_ser;
`else
   assign loop  = 1'b0;
   assign rx_in = rxd;
   assign txd   = tx_ser;
`endif

   always_comb begin
      bus.dout = '0;
      if (sel && bus.rd) begin
         case (idx)
            3'd0:    bus.dout = {rx_ne, 7'b0, rx_head};
            3'd1:    bus.dout = {11'b0, ferr, ovr, tx_full, tx_empty, rx_ne};
            3'd2:    bus.dout = div;
            3'd3:    bus.dout = {13'b0, loop, txie, rxie};
            default: bus.dout = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div  <= divrst;
         rxie <= 1'b0;
         txie <= 1'b0;
         ferr <= 1'b0;
         ovr  <= 1'b0;
         irq  <= 1'b0;
      end else begin
         if (div_wr && bus.wr[1]) div[15:8] <= bus.din[15:8];
         if (div_wr && bus.wr[0]) div[7:0]  <= bus.din[7:0];
         if (ctrl_wr && bus.wr[0]) begin
            rxie <= bus.din[0];
            txie <= bus.din[1];
         end
         // a new error event wins over a clear in the same cycle
         if (stat_wr && bus.din[4]) ferr <= 1'b0;
         if (stat_wr && bus.din[3]) ovr  <= 1'b0;
         if (ferr_set) ferr <= 1'b1;
         if (rx_push && !rx_wr) ovr <= 1'b1;
         irq <= (rxie && rx_ne) || (txie && tx_empty) || ferr || ovr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wp <= '0;
         tx_rp <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
         if (rx_wr)   rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[fdep-1:0]] <= wbyte;
      if (rx_wr)   rx_mem[rx_wp[fdep-1:0]] <= rx_sh;
   end

   always_comb begin
      tx_next = tx_state;
      tx_load = 1'b0;
      tx_ser  = 1'b1;
      case (tx_state)
         TX_IDLE: if (!tx_empty) begin
            tx_next = TX_START;
            tx_load = 1'b1;
         end
         TX_START: begin
            tx_ser = 1'b0;
            if (tx_cnt == '0) tx_next = TX_DATA;
         end
         TX_DATA: begin
            tx_ser = tx_sh[0];
            if (tx_cnt == '0 && tx_bit == 3'd7) tx_next = TX_STOP;
         end
         TX_STOP: if (tx_cnt == '0) begin
            if (!tx_empty) begin
               tx_next = TX_START;
               tx_load = 1'b1;
            end else begin
               tx_next = TX_IDLE;
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_div   <= '0;
         tx_sh    <= '0;
         tx_bit   <= '0;
      end else begin
         tx_state <= tx_next;
         if (tx_load) begin
            tx_div <= div;
            tx_cnt <= div;
            tx_sh  <= tx_mem[tx_rp[fdep-1:0]];
            tx_bit <= '0;
         end else if (tx_state != TX_IDLE) begin
            if (tx_cnt == '0) begin
               tx_cnt <= tx_div;
               if (tx_state == TX_DATA) begin
                  tx_sh  <= {1'b0, tx_sh[7:1]};
                  tx_bit <= tx_bit + 3'd1;
               end
            end else begin
               tx_cnt <= tx_cnt - 16'd1;
            end
         end
      end
   end

   assign rx_half = {1'b0, div[15:1]} + {15'b0, div[0]};
   assign rx_tick = (rx_cnt == '0);

   // Detection already sees the start bit one clock late, so the half-bit wait is
   // shortened by one; a zero half count treats the detect sample as the start check.
   always_comb begin
      rx_next   = rx_state;
      rx_detect = 1'b0;
      rx_push   = 1'b0;
      ferr_set  = 1'b0;
      case (rx_state)
         RX_IDLE: if (s3 && !s2) begin
            rx_detect = 1'b1;
            rx_next   = (rx_half == '0) ? RX_DATA : RX_START;
         end
         RX_START: if (rx_tick) rx_next = s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP: if (rx_tick) begin
            if (s2) begin
               rx_push = 1'b1;
               rx_next = RX_IDLE;
            end else begin
               ferr_set = 1'b1;
               rx_next  = RX_WAIT;
            end
         end
         RX_WAIT: if (s2) rx_next = RX_IDLE;
         default: rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1       <= 1'b1;
         s2       <= 1'b1;
         s3       <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_div   <= '0;
         rx_sh    <= '0;
         rx_bit   <= '0;
      end else begin
         s1       <= rx_in;
         s2       <= s1;
         s3       <= s2;
         rx_state <= rx_next;
         if (rx_detect) begin
            rx_div <= div;
            rx_bit <= '0;
            rx_cnt <= (rx_half == '0) ? div : rx_half - 16'd1;
         end else if (rx_state inside {RX_START, RX_DATA, RX_STOP}) begin
            if (rx_tick) begin
               rx_cnt <= rx_div;
               if (rx_state == RX_DATA) begin
                  rx_sh  <= {s2, rx_sh[7:1]};
                  rx_bit <= rx_bit + 3'd1;
               end
            end else begin
               rx_cnt <= rx_cnt - 16'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_b16_uart.sv
// Randomized self-checking bench for b16_uart against a queue-based model of the
// register file, the RX FIFO and the 8N1 frame format.
module tb_b16_uart;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rxd = 1'b1;
   logic irq, txd;

   b16_uart_if #(.l(16)) bus ();

   b16_uart #(.l(16), .ioaddr(12'hFFD), .fdep(2), .divrst(16'd433)) dut (
      .clk(clk), .reset(reset), .bus(bus), .irq(irq), .txd(txd), .rxd(rxd)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   logic [7:0] rx_q[$];
   logic [7:0] tx_exp[$];
   logic m_ferr, m_ovr;
   int cur_div;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [15:0] exp_stat();
      return {11'b0, m_ferr, m_ovr, 1'b0, 1'b1, rx_q.size() != 0};
   endfunction

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   task automatic bus_write(input logic [2:0] idx, input logic [15:0] data, input logic [1:0] lanes);
      @(negedge clk);
      bus.addr = {12'hFFD, idx};
      bus.din  = data;
      bus.wr   = lanes;
      @(posedge clk);
      #1 bus.wr = 2'b00;
   endtask

   task automatic bus_read(input logic [2:0] idx, output logic [15:0] data);
      @(negedge clk);
      bus.addr = {12'hFFD, idx};
      bus.rd   = 1'b1;
      #1 data = bus.dout;
      @(posedge clk);
      #1 bus.rd = 1'b0;
   endtask

   task automatic set_div(input int d);
      bus_write(3'd2, 16'(d), 2'b11);
      cur_div = d;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      @(posedge clk);
      #2;
      for (int k = 0; k < 10; k++) begin
         rxd = f[k];
         repeat (cur_div + 1) @(posedge clk);
         #2;
      end
      rxd = 1'b1;
      if (!stop) m_ferr = 1'b1;
      else if (rx_q.size() < 4) rx_q.push_back(b);
      else m_ovr = 1'b1;
      repeat (cur_div + 4) @(posedge clk);
   endtask

   task automatic drain_rx();
      logic [15:0] d;
      while (rx_q.size() != 0) begin
         bus_read(3'd0, d);
         check("rx_data", d, {1'b1, 7'b0, rx_q.pop_front()});
      end
      bus_read(3'd0, d);
      check("rx_empty_flag", 16'(d[15]), 16'h0);
   endtask

   task automatic tx_capture(input int n, input int d0, input int d1);
      int budget, d;
      logic [15:0] v, ev;
      budget = 0;
      @(posedge clk);
      #1;
      while (txd !== 1'b0 && budget < 100) begin
         @(posedge clk);
         #1 budget++;
      end
      check("tx_start_seen", 16'(txd), 16'h0);
      if (txd === 1'b0) begin
         for (int f = 0; f < n; f++) begin
            d = (f == 0) ? d0 : d1;
            for (int k = 0; k < 10; k++) begin
               v = '0;
               for (int s = 0; s <= d; s++) begin
                  v[s] = txd;
                  @(posedge clk);
                  #1;
               end
               ev = frame_bit(tx_exp[f], k) ? 16'((32'd1 << (d + 1)) - 32'd1) : 16'h0;
               check($sformatf("tx_f%0d_b%0d", f, k), v, ev);
            end
         end
      end
   endtask

   task automatic idle_high(input string tag, input int cycles);
      int cnt;
      cnt = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1 if (txd === 1'b1) cnt++;
      end
      check(tag, 16'(cnt), 16'(cycles));
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d, data;
      logic [1:0] lane;
      int n;
      bus.addr = '0; bus.rd = 1'b0; bus.wr = 2'b00; bus.din = '0;
      m_ferr = 1'b0; m_ovr = 1'b0; cur_div = 433;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check("irq_rst", 16'(irq), 16'h0);
      bus.addr = {12'hFFD, 3'd1};
      #1 check("dout_rd_low", bus.dout, 16'h0);
      bus_read(3'd1, d); check("stat_rst", d, 16'h0002);
      bus_read(3'd2, d); check("div_rst", d, 16'd433);
      bus_read(3'd3, d); check("ctrl_rst", d, 16'h0);
      bus_read(3'd5, d); check("reg5", d, 16'h0);
      @(negedge clk);
      bus.addr = {12'hFFC, 3'd1}; bus.rd = 1'b1;
      #1 check("unselected", bus.dout, 16'h0);
      @(posedge clk); #1 bus.rd = 1'b0;
      idle_high("txd_idle_1000", 1000);

      bus_write(3'd3, 16'h00FF, 2'b11);
      bus_read(3'd3, d);
`ifdef UART_LOOPBACK_EN
      check("ctrl_rw", d, 16'h0007);
`else
      check("ctrl_rw", d, 16'h0003);
`endif
      bus_write(3'd3, 16'h0000, 2'b11);
      bus_write(3'd2, 16'hAB00, 2'b10);
      bus_read(3'd2, d); check("div_hi_lane", d, 16'hABB1);

      set_div(3);
      tx_exp.delete(); tx_exp.push_back(8'hA5);
      fork
         bus_write(3'd0, 16'h00A5, 2'b01);
         tx_capture(1, 3, 3);
      join

      for (int r = 0; r < 6; r++) begin
         set_div($urandom_range(0, 7));
         n = $urandom_range(1, 3);
         tx_exp.delete();
         for (int i = 0; i < n; i++) tx_exp.push_back(8'($urandom));
         fork
            for (int i = 0; i < n; i++) begin
               lane = 2'($urandom_range(1, 3));
               data = 16'($urandom);
               if (lane == 2'b10) data[15:8] = tx_exp[i];
               else data[7:0] = tx_exp[i];
               bus_write(3'd0, data, lane);
            end
            tx_capture(n, cur_div, cur_div);
         join
         idle_high("tx_rand_idle", 3);
         bus_read(3'd1, d); check("tx_rand_stat", d, exp_stat());
      end

      set_div(3);
      tx_exp.delete(); tx_exp.push_back(8'h5A); tx_exp.push_back(8'hC3);
      fork
         begin
            bus_write(3'd0, 16'h005A, 2'b01);
            bus_write(3'd0, 16'h00C3, 2'b01);
            repeat (5) @(posedge clk);
            set_div(7);
         end
         tx_capture(2, 3, 7);
      join

      set_div(1);
      tx_exp.delete();
      for (int i = 0; i < 6; i++) tx_exp.push_back(8'($urandom));
      fork
         begin
            for (int i = 0; i < 6; i++) bus_write(3'd0, {8'h00, tx_exp[i]}, 2'b01);
            bus_read(3'd1, d); check("tx_full_stat", d, 16'h0004);
         end
         tx_capture(5, 1, 1);
      join
      idle_high("tx_drop_6th", 40);

      set_div(3);
      bus_write(3'd3, 16'h0001, 2'b01);
      send_frame(8'h3C, 1'b1);
      check("irq_rxie", 16'(irq), 16'h1);
      bus_read(3'd1, d); check("stat_rx_ne", d, exp_stat());
      drain_rx();
      bus_read(3'd1, d); check("stat_after_pop", d, 16'h0002);
      repeat (2) @(posedge clk);
      #1 check("irq_rx_clear", 16'(irq), 16'h0);
      bus_write(3'd3, 16'h0002, 2'b01);
      repeat (2) @(posedge clk);
      #1 check("irq_txie", 16'(irq), 16'h1);
      bus_write(3'd3, 16'h0000, 2'b01);
      repeat (2) @(posedge clk);
      #1 check("irq_off", 16'(irq), 16'h0);

      for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
      bus_read(3'd1, d); check("stat_ovr", d, exp_stat());
      check("irq_ovr", 16'(irq), 16'h1);
      drain_rx();
      bus_write(3'd1, 16'h0008, 2'b01);
      m_ovr = 1'b0;
      bus_read(3'd1, d); check("stat_ovr_clr", d, exp_stat());

      set_div(7);
      @(posedge clk); #2 rxd = 1'b0;
      @(posedge clk); #2 rxd = 1'b1;
      repeat (40) @(posedge clk);
      bus_read(3'd1, d); check("glitch_ignored", d, exp_stat());
      send_frame(8'h77, 1'b0);
      bus_read(3'd1, d); check("stat_ferr", d, exp_stat());
      bus_write(3'd1, 16'h0010, 2'b01);
      m_ferr = 1'b0;
      bus_read(3'd1, d); check("stat_ferr_clr", d, exp_stat());

      for (int r = 0; r < 4; r++) begin
         set_div($urandom_range(0, 7));
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) send_frame(8'($urandom), ($urandom_range(0, 5) != 0));
         bus_read(3'd1, d); check("rx_rand_stat", d, exp_stat());
         check("rx_rand_irq", 16'(irq), 16'(m_ferr | m_ovr));
         drain_rx();
         bus_write(3'd1, 16'h0018, 2'b01);
         m_ferr = 1'b0; m_ovr = 1'b0;
         bus_read(3'd1, d); check("rx_rand_clr", d, exp_stat());
      end

`ifdef UART_LOOPBACK_EN
      set_div(3);
      bus_write(3'd3, 16'h0004, 2'b01);
      fork
         begin
            bus_write(3'd0, 16'h0000, 2'b01);
            bus_write(3'd0, 16'h00FF, 2'b01);
         end
         idle_high("loop_txd_high", 120);
      join
      rx_q.push_back(8'h00); rx_q.push_back(8'hFF);
      drain_rx();
      bus_write(3'd3, 16'h0000, 2'b01);
`endif

      set_div(7);
      fork
         bus_write(3'd0, 16'h0000, 2'b01);
         begin @(posedge clk); #2 rxd = 1'b0; end
      join
      repeat (20) @(posedge clk);
      #1 check("tx_mid_frame", 16'(txd), 16'h0);
      @(negedge clk);
      reset = 1'b1; rxd = 1'b1;
      @(posedge clk);
      #1 check("txd_after_rst", 16'(txd), 16'h1);
      @(negedge clk) reset = 1'b0;
      cur_div = 433;
      repeat (30) @(posedge clk);
      bus_read(3'd1, d); check("stat_after_rst", d, 16'h0002);
      bus_read(3'd2, d); check("div_after_rst", d, 16'd433);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
